// File: rtl/tft_text_scroller.sv
// Port-B arbiter and text engine for the TFT character memory.
// While idle the CPU bus passes straight through to the memory port. While a
// command runs, the engine owns the port and the CPU is stalled.
// Scroll copies each word up by one row, then fills the last row.
// Clear fills every character cell with the latched fill byte.
module tft_text_scroller #(
    parameter  int MEM_SIZE = 8192,
    parameter  int COLS     = 100,
    parameter  int ROWS     = 30,
    localparam int ADDR_W   = $clog2(MEM_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_data_i,
    input  logic [3:0]        cpu_data_en,
    input  logic              cpu_write_en,
    output logic              cpu_ready,
    output logic [31:0]       cpu_data_o,
    input  logic              cmd_scroll,
    input  logic              cmd_clear,
    input  logic [7:0]        fill_char,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr_b,
    output logic [31:0]       mem_data_i_b,
    input  logic [31:0]       mem_data_o_b,
    output logic [3:0]        mem_data_en_b,
    output logic              mem_write_en_b
);

    localparam int IW        = ADDR_W - 2;
    localparam int ROW_WORDS = COLS / 4;
    localparam int FILL_BASE = (ROWS - 1) * ROW_WORDS;
    localparam int LAST_SCR  = FILL_BASE - 1;
    localparam int LAST_FILL = ROWS * ROW_WORDS - 1;

    typedef enum logic [2:0] {
        IDLE,
        SCR_RD,
        SCR_WR,
        FILL,
        DONE
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [7:0]      fill_q;
    logic            busy_q;
    logic            done_q;
    logic            port_free;

    // DONE behaves like IDLE for CPU access and command acceptance.
    assign port_free = (state_q == IDLE) || (state_q == DONE);

    // Command sequencer: registered busy/done track the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            fill_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (cmd_clear) begin
                        fill_q  <= fill_char;
                        idx_q   <= '0;
                        state_q <= FILL;
                        busy_q  <= 1'b1;
                    end else if (cmd_scroll) begin
                        fill_q  <= fill_char;
                        idx_q   <= '0;
                        // A single-row screen has nothing to copy.
                        state_q <= (ROWS == 1) ? FILL : SCR_RD;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                SCR_RD: begin
                    state_q <= SCR_WR;
                end
                SCR_WR: begin
                    if (idx_q == IW'(LAST_SCR)) begin
                        idx_q   <= IW'(FILL_BASE);
                        state_q <= FILL;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= SCR_RD;
                    end
                end
                FILL: begin
                    if (idx_q == IW'(LAST_FILL)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Memory port mux: CPU pass-through when free, engine drive otherwise.
    always_comb begin
        mem_addr_b     = cpu_addr;
        mem_data_i_b   = cpu_data_i;
        mem_data_en_b  = cpu_data_en;
        mem_write_en_b = 1'b0;
        cpu_ready      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                mem_write_en_b = cpu_req & cpu_write_en;
                cpu_ready      = cpu_req;
            end
            SCR_RD: begin
                // Source word sits one row below the destination.
                mem_addr_b    = {idx_q + IW'(ROW_WORDS), 2'b00};
                mem_data_en_b = 4'h0;
            end
            SCR_WR: begin
                // Read data from the previous cycle's SCR_RD is on mem_data_o_b.
                mem_addr_b     = {idx_q, 2'b00};
                mem_data_i_b   = mem_data_o_b;
                mem_data_en_b  = 4'hF;
                mem_write_en_b = 1'b1;
            end
            FILL: begin
                mem_addr_b     = {idx_q, 2'b00};
                mem_data_i_b   = {4{fill_q}};
                mem_data_en_b  = 4'hF;
                mem_write_en_b = 1'b1;
            end
            default: begin
                mem_write_en_b = 1'b0;
            end
        endcase
        // Unused when busy; kept to make the free-port condition explicit.
        if (!port_free) cpu_ready = 1'b0;
    end

    assign cpu_data_o = mem_data_o_b;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
